// File: rtl/test_03_bist_ctrl_if.sv
// test_03_bist_ctrl_if: test-control and datapath signals of the test_03 BIST controller.
interface test_03_bist_ctrl_if #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 7
);
  logic             start;
  logic             abort;
  logic [OUT_W-1:0] golden;
  logic [OUT_W-1:0] resp_i;
  logic [IN_W-1:0]  vec_o;
  logic [IN_W-1:0]  cnt_o;
  logic             vec_valid;
  logic             busy;
  logic             done;
  logic             pass;
  logic [OUT_W-1:0] sig_o;
  modport master (
    output start, abort, golden, resp_i,
    input  vec_o, cnt_o, vec_valid, busy, done, pass, sig_o
  );
  modport slave (
    input  start, abort, golden, resp_i,
    output vec_o, cnt_o, vec_valid, busy, done, pass, sig_o
  );
endinterface

// File: rtl/test_03_bist_ctrl.sv
// test_03_bist_ctrl: exhaustive vector sequencer with MISR compaction and golden-signature compare.
module test_03_bist_ctrl #(
  parameter int             IN_W   = 5,
  parameter int             OUT_W  = 7,
  parameter int             SETTLE = 1,
  parameter logic [OUT_W-1:0] POLY = 'h03
) (
  input logic               clk,
  input logic               rst_n,
  test_03_bist_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  // With no settle time every cycle of a run is a capture cycle.
  localparam state_t RUN = (SETTLE == 0) ? CAPTURE : APPLY;
  state_t           state;
  logic [SW-1:0]    st;
  logic [IN_W-1:0]  vec;
  logic [OUT_W-1:0] sig;
  logic [OUT_W-1:0] sig_nx;
  logic             vec_valid, busy, done, pass;
  assign sig_nx        = {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? POLY : '0) ^ bus.resp_i;
  assign bus.vec_o     = vec;
  assign bus.cnt_o     = vec;
  assign bus.sig_o     = sig;
  assign bus.vec_valid = vec_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = pass;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      st        <= '0;
      vec       <= '0;
      sig       <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.abort && state != IDLE) begin
        state     <= IDLE;
        vec_valid <= 1'b0;
        busy      <= 1'b0;
        pass      <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.start && !bus.abort) begin
            state     <= RUN;
            st        <= '0;
            vec       <= '0;
            sig       <= '0;
            pass      <= 1'b0;
            vec_valid <= 1'b1;
            busy      <= 1'b1;
          end
          APPLY: begin
            st <= st + 1'b1;
            if (st == SW'(SETTLE - 1)) state <= CAPTURE;
          end
          CAPTURE: begin
            sig <= sig_nx;
            st  <= '0;
            // Pass is decided here so it is already valid during the done pulse.
            if (vec == '1) begin
              state     <= DONE;
              done      <= 1'b1;
              vec_valid <= 1'b0;
              pass      <= (sig_nx == bus.golden);
            end else begin
              vec   <= vec + 1'b1;
              state <= RUN;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_test_03_bist_ctrl.sv
// tb_test_03_bist_ctrl: directed runs on a default instance and a 2-bit/no-settle instance, scoreboarded done results.
module tb_test_03_bist_ctrl;
  typedef struct {
    logic [6:0] sig;
    logic       pass;
    int         lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_mode = 1'b0;
  logic b_mode = 1'b0;
  int   cyc = 0;
  int   ncmp = 0;
  int   nerr = 0;
  int   a_t0 = 0;
  int   b_t0 = 0;
  logic a_pb = 1'b0;
  logic b_pb = 1'b0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  test_03_bist_ctrl_if #(.IN_W(5), .OUT_W(7)) a_if();
  test_03_bist_ctrl_if #(.IN_W(2), .OUT_W(7)) b_if();
  test_03_bist_ctrl u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  test_03_bist_ctrl #(.IN_W(2), .SETTLE(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  assign a_if.resp_i = a_mode ? (7'(a_if.vec_o) ^ 7'h55) : 7'h00;
  assign b_if.resp_i = b_mode ? 7'h7F : 7'(b_if.vec_o);
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [6:0] model_a(input int n);
    logic [6:0] s = 7'h00;
    for (int i = 0; i < n; i++) s = {s[5:0], 1'b0} ^ (s[6] ? 7'h03 : 7'h00) ^ (7'(i) ^ 7'h55);
    return s;
  endfunction
  task automatic push_a(input logic [6:0] s, input logic p);
    exp_t e;
    e.sig = s; e.pass = p; e.lat = 64;
    sb_a.push_back(e);
  endtask
  task automatic push_b(input logic [6:0] s, input logic p);
    exp_t e;
    e.sig = s; e.pass = p; e.lat = 4;
    sb_b.push_back(e);
  endtask
  task automatic wait_a(input string tag);
    for (int i = 0; i < 200 && !a_if.done; i++) tick();
    chk(tag, a_if.done, 1);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (a_if.busy && !a_pb) a_t0 = cyc;
    a_pb = a_if.busy;
    if (a_if.done) begin
      chk("a_done_expected", 32'(sb_a.size() > 0), 1);
      if (sb_a.size() > 0) begin
        e = sb_a.pop_front();
        chk("a_sig", a_if.sig_o, e.sig);
        chk("a_pass", a_if.pass, e.pass);
        chk("a_latency", cyc - a_t0, e.lat);
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (b_if.busy && !b_pb) b_t0 = cyc;
    b_pb = b_if.busy;
    if (b_if.done) begin
      chk("b_done_expected", 32'(sb_b.size() > 0), 1);
      if (sb_b.size() > 0) begin
        e = sb_b.pop_front();
        chk("b_sig", b_if.sig_o, e.sig);
        chk("b_pass", b_if.pass, e.pass);
        chk("b_latency", cyc - b_t0, e.lat);
      end
    end
  end
  initial begin
    a_if.start = 0; a_if.abort = 0; a_if.golden = 0;
    b_if.start = 0; b_if.abort = 0; b_if.golden = 0;
    repeat (2) tick();
    chk("a_reset", {a_if.vec_o, a_if.cnt_o, a_if.vec_valid, a_if.busy, a_if.done, a_if.pass, a_if.sig_o}, 0);
    chk("b_reset", {b_if.vec_o, b_if.cnt_o, b_if.vec_valid, b_if.busy, b_if.done, b_if.pass, b_if.sig_o}, 0);
    @(negedge clk) rst_n = 1;
    tick();
    // Small instance, resp = vec: vectors 0..3 on consecutive cycles, signature 03.
    b_mode = 0; b_if.golden = 7'h03;
    push_b(7'h03, 1);
    b_if.start = 1; tick(); b_if.start = 0;
    chk("b1_busy", b_if.busy, 1);
    chk("b1_valid", b_if.vec_valid, 1);
    for (int v = 0; v < 4; v++) begin
      chk("b1_vec", b_if.vec_o, v);
      chk("b1_cnt", b_if.cnt_o, v);
      tick();
    end
    chk("b1_done", b_if.done, 1);
    chk("b1_valid_done", b_if.vec_valid, 0);
    tick();
    chk("b1_idle", {b_if.busy, b_if.done}, 0);
    tick();
    chk("b1_pass_held", {b_if.pass, b_if.sig_o, b_if.vec_o}, {1'b1, 7'h03, 2'd3});
    // Constant 7F response: signature walks 7F,02,7B,0A and misses golden 0B.
    b_mode = 1; b_if.golden = 7'h0B;
    push_b(7'h0A, 0);
    b_if.start = 1; tick(); b_if.start = 0;
    chk("b2_pass_cleared", b_if.pass, 0);
    chk("b2_sig0", b_if.sig_o, 7'h00);
    tick(); chk("b2_sig1", b_if.sig_o, 7'h7F);
    tick(); chk("b2_sig2", b_if.sig_o, 7'h02);
    tick(); chk("b2_sig3", b_if.sig_o, 7'h7B);
    tick(); chk("b2_sig4", b_if.sig_o, 7'h0A);
    chk("b2_done", b_if.done, 1);
    tick();
    // Default instance, zero response: each vector held two cycles.
    a_mode = 0; a_if.golden = 7'h00;
    push_a(7'h00, 1);
    a_if.start = 1; tick(); a_if.start = 0;
    chk("a3_vec0a", a_if.vec_o, 0);
    tick(); chk("a3_vec0b", a_if.vec_o, 0);
    tick(); chk("a3_vec1", a_if.vec_o, 1);
    wait_a("a3_done_seen");
    tick();
    chk("a3_busy_after", a_if.busy, 0);
    chk("a3_pass_held", a_if.pass, 1);
    // Abort at vector 10 in APPLY, then restart one cycle later.
    a_mode = 1; a_if.golden = model_a(32);
    a_if.start = 1; tick(); a_if.start = 0;
    repeat (20) tick();
    chk("a4_vec10", a_if.vec_o, 10);
    chk("a4_sig10", a_if.sig_o, model_a(10));
    a_if.abort = 1; tick(); a_if.abort = 0;
    chk("a4_abort_state", {a_if.busy, a_if.vec_valid, a_if.pass, a_if.done}, 0);
    chk("a4_freeze", {a_if.vec_o, a_if.sig_o}, {5'd10, model_a(10)});
    push_a(model_a(32), 1);
    a_if.start = 1; tick(); a_if.start = 0;
    chk("a4_restart", {a_if.busy, a_if.vec_o, a_if.sig_o}, {1'b1, 5'd0, 7'h00});
    wait_a("a4_done_seen");
    tick();
    // Start held 80 cycles: one run, then a second from the cycle after done.
    push_a(model_a(32), 1);
    push_a(model_a(32), 1);
    a_if.start = 1;
    repeat (80) tick();
    a_if.start = 0;
    chk("a5_second_run", {a_if.busy, a_if.vec_o}, {1'b1, 5'd6});
    wait_a("a5_done_seen");
    tick();
    // Asynchronous reset during CAPTURE.
    a_if.start = 1; tick(); a_if.start = 0;
    tick();
    #2 rst_n = 0;
    #1;
    chk("a6_async_reset", {a_if.vec_o, a_if.cnt_o, a_if.vec_valid, a_if.busy, a_if.done, a_if.pass, a_if.sig_o}, 0);
    @(negedge clk) rst_n = 1;
    push_a(model_a(32), 1);
    a_if.start = 1; tick(); a_if.start = 0;
    chk("a6_clean_start", {a_if.busy, a_if.vec_o, a_if.sig_o}, {1'b1, 5'd0, 7'h00});
    wait_a("a6_done_seen");
    repeat (3) tick();
    chk("sb_a_drained", sb_a.size(), 0);
    chk("sb_b_drained", sb_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
